fp_op_sequencer: RTL and testbench

- Initiator-side controller for the floating-point mul/div unit.
- Accepts single-precision operand requests over a valid/ready interface.
- Drives operands, `sel` and `en` into the FP unit and holds them stable for the unit's fixed pipeline latency.
- Captures the result word and the five exception flags, then returns them over a valid/ready response interface. It also keeps sticky exception flags and a completed-operation counter for software status.

---
 rtl/fp_op_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fp_op_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_op_sequencer.sv
// -----------------------------------------------------------------------------
// fp_op_sequencer
//   Initiator-side controller for a fixed-latency floating-point mul/div unit.
//   It accepts one operand request at a time and drives the operands, op select
//   and enable into the FP unit. It holds them stable for LATENCY enabled edges,
//   captures the result and exception flags, and then presents them on a
//   valid/ready response port. It also keeps sticky exception flags and a
//   count of completed response handshakes.
//
// Ports
//   clk, arst             clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   request handshake; req_a, req_b operands, req_op 1=mul 0=div
//   rsp_valid/rsp_ready   response handshake; rsp_r result, rsp_flags {io,dz,of,uf,i}
//   sticky_flags          OR of captured flags since the last sticky_clr
//   sticky_clr            clear sticky_flags (a coincident capture still sets its flags)
//   op_count              completed response handshakes, wraps at 2^CNT_W
//   busy                  sequencer is not idle
//   fpu_a, fpu_b, fpu_sel, fpu_en   drive into the FP unit
//   fpu_r, fpu_io..fpu_i  result and flags from the FP unit
// -----------------------------------------------------------------------------
module fp_op_sequencer #(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic             req_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_r,
   output logic [4:0]       rsp_flags,
   output logic [4:0]       sticky_flags,
   input  logic             sticky_clr,
   output logic [CNT_W-1:0] op_count,
   output logic             busy,
   output logic [31:0]      fpu_a,
   output logic [31:0]      fpu_b,
   output logic             fpu_sel,
   output logic             fpu_en,
   input  logic [31:0]      fpu_r,
   input  logic             fpu_io,
   input  logic             fpu_dz,
   input  logic             fpu_of,
   input  logic             fpu_uf,
   input  logic             fpu_i
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_SAMPLE = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   // LATENCY is at most 15, so a 4-bit counter always reaches LATENCY-1.
   localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

   state_t             state_q;
   logic [3:0]         cnt_q;
   logic [31:0]        fpu_a_q;
   logic [31:0]        fpu_b_q;
   logic               fpu_sel_q;
   logic               fpu_en_q;
   logic               rsp_valid_q;
   logic [31:0]        rsp_r_q;
   logic [4:0]         rsp_flags_q;
   logic [4:0]         sticky_q;
   logic [4:0]         sticky_d;
   logic [CNT_W-1:0]   op_count_q;
   logic [4:0]         cap_flags_s;

   assign cap_flags_s = {fpu_io, fpu_dz, fpu_of, fpu_uf, fpu_i};

   // Sticky next state: a clear coincident with capture drops the old flags
   // but keeps the freshly captured ones.
   always_comb begin
      sticky_d = sticky_q;
      if (state_q == S_SAMPLE) begin
         if (sticky_clr) begin
            sticky_d = cap_flags_s;
         end else begin
            sticky_d = sticky_q | cap_flags_s;
         end
      end else if (sticky_clr) begin
         sticky_d = 5'd0;
      end else begin
         sticky_d = sticky_q;
      end
   end

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (arst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         fpu_a_q     <= 32'd0;
         fpu_b_q     <= 32'd0;
         fpu_sel_q   <= 1'b0;
         fpu_en_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_r_q     <= 32'd0;
         rsp_flags_q <= 5'd0;
         sticky_q    <= 5'd0;
         op_count_q  <= '0;
      end else begin
         sticky_q <= sticky_d;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  fpu_a_q   <= req_a;
                  fpu_b_q   <= req_b;
                  fpu_sel_q <= req_op;
                  fpu_en_q  <= 1'b1;
                  cnt_q     <= 4'd0;
                  state_q   <= S_WAIT;
               end else begin
                  fpu_en_q  <= 1'b0;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q + 4'd1;
               // The LATENCY-th enabled edge is the one seen with cnt_q at LAST_CNT.
               if (cnt_q == LAST_CNT) begin
                  fpu_en_q <= 1'b0;
                  state_q  <= S_SAMPLE;
               end else begin
                  fpu_en_q <= 1'b1;
               end
            end
            S_SAMPLE: begin
               rsp_r_q     <= fpu_r;
               rsp_flags_q <= cap_flags_s;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  op_count_q  <= op_count_q + CNT_W'(1);
                  state_q     <= S_IDLE;
               end else begin
                  rsp_valid_q <= 1'b1;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               fpu_en_q <= 1'b0;
            end
         endcase
      end
   end

   // Acceptance is blocked in any cycle where reset is active.
   assign req_ready    = (state_q == S_IDLE) && !arst;
   assign busy         = (state_q != S_IDLE);
   assign rsp_valid    = rsp_valid_q;
   assign rsp_r        = rsp_r_q;
   assign rsp_flags    = rsp_flags_q;
   assign sticky_flags = sticky_q;
   assign op_count     = op_count_q;
   assign fpu_a        = fpu_a_q;
   assign fpu_b        = fpu_b_q;
   assign fpu_sel      = fpu_sel_q;
   assign fpu_en       = fpu_en_q;

endmodule

// File: tb/tb_fp_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fp_op_sequencer
//   Bench for fp_op_sequencer with LATENCY = 4 and CNT_W = 4. A registered FP
//   unit model advances only on enabled edges and returns table-driven results.
//   Expected responses are queued when a request is accepted and compared when
//   the response handshake happens.
// -----------------------------------------------------------------------------
module tb_fp_op_sequencer;

   localparam int LAT = 4;
   localparam int CW  = 4;

   logic          clk = 1'b0;
   logic          arst;
   logic          req_valid;
   logic          req_ready;
   logic [31:0]   req_a;
   logic [31:0]   req_b;
   logic          req_op;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_r;
   logic [4:0]    rsp_flags;
   logic [4:0]    sticky_flags;
   logic          sticky_clr;
   logic [CW-1:0] op_count;
   logic          busy;
   logic [31:0]   fpu_a;
   logic [31:0]   fpu_b;
   logic          fpu_sel;
   logic          fpu_en;
   logic [31:0]   fpu_r;
   logic          fpu_io, fpu_dz, fpu_of, fpu_uf, fpu_i;

   fp_op_sequencer #(.LATENCY(LAT), .CNT_W(CW)) dut (
      .clk(clk), .arst(arst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_r(rsp_r), .rsp_flags(rsp_flags),
      .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
      .op_count(op_count), .busy(busy),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_sel(fpu_sel), .fpu_en(fpu_en),
      .fpu_r(fpu_r), .fpu_io(fpu_io), .fpu_dz(fpu_dz), .fpu_of(fpu_of),
      .fpu_uf(fpu_uf), .fpu_i(fpu_i)
   );

   always #5 clk = ~clk;

   // FP unit model: {result, flags} for the operand pairs used here.
   function automatic logic [36:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic sel);
      logic [36:0] res;
      res = {32'hDEAD0000 ^ a ^ b, 5'b00000};
      if (sel) begin
         if (a == 32'h40000000 && b == 32'h40400000) res = {32'h40C00000, 5'b00000};
         if (a == 32'h3FC00000 && b == 32'h40000000) res = {32'h40400000, 5'b00000};
         if (a == 32'h40400000 && b == 32'h40000000) res = {32'h40C00000, 5'b00000};
         if (a == 32'h7F000000 && b == 32'h7F000000) res = {32'h7F800000, 5'b00100};
      end else begin
         if (b[30:0] == 31'd0)                       res = {32'h7F800000, 5'b01000};
         if (a == 32'h40000000 && b == 32'h3F800000) res = {32'h40000000, 5'b00000};
         if (a == 32'h40C00000 && b == 32'h40000000) res = {32'h40400000, 5'b00000};
         if (a == 32'h40800000 && b == 32'h40000000) res = {32'h40000000, 5'b00000};
      end
      return res;
   endfunction

   logic [36:0] pipe [LAT];
   always @(posedge clk) begin
      if (fpu_en) begin
         pipe[0] <= fpu_fn(fpu_a, fpu_b, fpu_sel);
         for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
   end
   assign fpu_r = pipe[LAT-1][36:5];
   assign {fpu_io, fpu_dz, fpu_of, fpu_uf, fpu_i} = pipe[LAT-1][4:0];

   typedef struct packed {
      logic [31:0] r;
      logic [4:0]  f;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic [31:0] r;
      logic [4:0]  f;
   } vec_t;

   exp_t    exp_q[$];
   vec_t    vecs[5];
   int      n_checks = 0;
   int      n_errors = 0;
   logic [4:0]    exp_sticky = 5'd0;
   logic [CW-1:0] exp_cnt = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One complete operation; clr pulses sticky_clr on the SAMPLE edge,
   // hold keeps rsp_ready low for that many cycles after rsp_valid.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [31:0] er, input logic [4:0] ef,
                         input bit clr, input int hold);
      int   n;
      int   en_n;
      exp_t e;
      req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 40) begin @(negedge clk); n++; end
      chk("accept_timeout", 32'(n < 40), 32'd1);
      e.r = er; e.f = ef;
      exp_q.push_back(e);
      @(negedge clk);
      // Garbage request held valid while busy must not disturb the operation.
      req_a = ~a; req_b = ~b; req_op = ~op;
      rsp_ready = 1'b1;
      chk("busy_after_accept", 32'(busy), 32'd1);
      n = 1; en_n = 0;
      while (!rsp_valid && n < 40) begin
         if (fpu_en) en_n++;
         sticky_clr = (clr && busy && !fpu_en) ? 1'b1 : 1'b0;
         @(negedge clk);
         n++;
      end
      sticky_clr = 1'b0;
      chk("en_cycles", 32'(en_n), 32'(LAT));
      chk("rsp_latency", 32'(n), 32'(LAT + 2));
      chk("fpu_a_held", fpu_a, a);
      chk("fpu_b_held", fpu_b, b);
      chk("fpu_sel_held", 32'(fpu_sel), 32'(op));
      e = exp_q.pop_front();
      exp_sticky = clr ? e.f : (exp_sticky | e.f);
      chk("rsp_r", rsp_r, e.r);
      chk("rsp_flags", 32'(rsp_flags), 32'(e.f));
      chk("sticky", 32'(sticky_flags), 32'(exp_sticky));
      rsp_ready = (hold == 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_r", rsp_r, e.r);
         chk("bp_flags", 32'(rsp_flags), 32'(e.f));
         chk("bp_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b0;
      exp_cnt = exp_cnt + 1'b1;
      chk("op_count", 32'(op_count), 32'(exp_cnt));
      chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
      chk("idle_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      int rv;
      vecs[0] = '{32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 5'b00000};
      vecs[1] = '{32'h3F800000, 32'h00000000, 1'b0, 32'h7F800000, 5'b01000};
      vecs[2] = '{32'h40000000, 32'h3F800000, 1'b0, 32'h40000000, 5'b00000};
      vecs[3] = '{32'h3FC00000, 32'h40000000, 1'b1, 32'h40400000, 5'b00000};
      vecs[4] = '{32'h40C00000, 32'h40000000, 1'b0, 32'h40400000, 5'b00000};

      arst = 1'b1; req_valid = 1'b0; req_a = 32'd0; req_b = 32'd0; req_op = 1'b0;
      rsp_ready = 1'b0; sticky_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fpu_en", 32'(fpu_en), 32'd0);
      chk("rst_fpu_a", fpu_a, 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_r", rsp_r, 32'd0);
      chk("rst_sticky", 32'(sticky_flags), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);
      arst = 1'b0;
      #1;
      chk("rst_release_ready", 32'(req_ready), 32'd1);
      @(negedge clk);

      for (int i = 0; i < 5; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].r, vecs[i].f, 1'b0, 0);

      // Backpressure, then the waiting request is taken in IDLE.
      run_op(32'h40400000, 32'h40000000, 1'b1, 32'h40C00000, 5'b00000, 1'b0, 10);
      run_op(32'h40800000, 32'h40000000, 1'b0, 32'h40000000, 5'b00000, 1'b0, 0);

      // Clear coincident with capture of an overflow.
      run_op(32'h7F000000, 32'h7F000000, 1'b1, 32'h7F800000, 5'b00100, 1'b1, 0);
      chk("sticky_clr_capture", 32'(sticky_flags), 32'h04);

      // Clear on its own.
      sticky_clr = 1'b1;
      @(negedge clk);
      sticky_clr = 1'b0;
      exp_sticky = 5'd0;
      chk("sticky_clr_alone", 32'(sticky_flags), 32'd0);

      run_op(vecs[1].a, vecs[1].b, vecs[1].op, vecs[1].r, vecs[1].f, 1'b0, 0);

      // Reset during WAIT with the counter at 2.
      req_a = 32'h40000000; req_b = 32'h40400000; req_op = 1'b1; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_busy", 32'(busy), 32'd1);
      repeat (2) @(negedge clk);
      arst = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_en", 32'(fpu_en), 32'd0);
      chk("mid_rst_sticky", 32'(sticky_flags), 32'd0);
      chk("mid_rst_count", 32'(op_count), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd0);
      arst = 1'b0;
      #1;
      chk("mid_rst_ready_rel", 32'(req_ready), 32'd1);
      rv = 0;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid) rv++;
      end
      chk("mid_rst_no_rsp", 32'(rv), 32'd0);
      exp_cnt = '0;
      exp_sticky = 5'd0;

      // Counter wrap with a 4-bit op_count.
      for (int i = 0; i < 17; i++)
         run_op(vecs[i % 5].a, vecs[i % 5].b, vecs[i % 5].op,
                vecs[i % 5].r, vecs[i % 5].f, 1'b0, 0);
      chk("wrap_final", 32'(op_count), 32'd1);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
